// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared state encoding and last-index helper for the register dump unit.
package reg_dump_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, SEND = 3'd2, CSUM = 3'd3, DONE = 3'd4} state_t;
  function automatic int last_idx(input int r_size);
    return (1 << r_size) - 1;
  endfunction
endpackage

// File: rtl/reg_dump.sv
// reg_dump: walks every GPR over the async read port and streams each value out on valid/ready.
// Optional REG_DUMP_CHECKSUM_EN appends a mod-2^N sum of the dumped words as a final stream word.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int N      = 8,
  parameter int R_SIZE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startIn,
  output logic [R_SIZE-1:0] regAddressOut,
  input  logic [N-1:0]      regDataIn,
  output logic [N-1:0]      txDataOut,
  output logic              txValidOut,
  input  logic              txReadyIn,
  output logic              busyOut,
  output logic              doneOut
);
  localparam logic [R_SIZE-1:0] LAST = R_SIZE'(last_idx(R_SIZE));
  state_t            r_state, w_next;
  logic [R_SIZE-1:0] r_index;
  logic [N-1:0]      r_tx_data;
  logic              r_tx_valid;
  logic              w_accept, w_last;
  assign w_accept      = r_tx_valid && txReadyIn;
  assign w_last        = r_index == LAST;
  assign regAddressOut = r_index;
  assign txDataOut     = r_tx_data;
  assign txValidOut    = r_tx_valid;
  assign busyOut       = r_state != IDLE;
  assign doneOut       = r_state == DONE;
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = startIn ? LOAD : IDLE;
      LOAD: w_next = SEND;
`ifdef REG_DUMP_CHECKSUM_EN
      SEND: w_next = !w_accept ? SEND : w_last ? CSUM : LOAD;
      CSUM: w_next = w_accept ? DONE : CSUM;
`else
      SEND: w_next = !w_accept ? SEND : w_last ? DONE : LOAD;
`endif
      default: w_next = IDLE;
    endcase
  end
`ifdef REG_DUMP_CHECKSUM_EN
  logic [N-1:0] r_acc;
  always_ff @(posedge clk) begin
    if (reset || r_state == IDLE) r_acc <= '0;
    else if (r_state == LOAD) r_acc <= r_acc + regDataIn;
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_index    <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      if (r_state == IDLE) r_index <= '0;
      if (r_state == LOAD) begin
        r_tx_data  <= regDataIn;
        r_tx_valid <= 1'b1;
      end
      if (r_state == SEND && w_accept) begin
        r_tx_valid <= 1'b0;
        if (!w_last) r_index <= r_index + 1'b1;
      end
`ifdef REG_DUMP_CHECKSUM_EN
      // First CSUM cycle loads the sum, later cycles wait for the handshake like SEND.
      if (r_state == CSUM && !r_tx_valid) begin
        r_tx_data  <= r_acc;
        r_tx_valid <= 1'b1;
      end else if (r_state == CSUM && w_accept) r_tx_valid <= 1'b0;
`endif
    end
  end
endmodule

// File: doc/reg_dump.md
# reg_dump

Debug read-out unit for the picoMIPS general-purpose register file. On a start pulse it walks GPR addresses 0 to 2^R_SIZE−1 over the register file's asynchronous read port and emits each value as one word on a valid/ready output stream. It is the reader counterpart to the datapath's synchronous write port and sits beside the register file, feeding a debug transmitter.

## Interface
Parameters:
- N, 8, data word width; matches the register file data width.
- R_SIZE, 3, GPR address width; the dump covers 2^R_SIZE words.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- startIn  input  1  dump request; sampled only in IDLE.
- regAddressOut  output  R_SIZE  read address driven to the register file's source read port.
- regDataIn  input  N  asynchronous read data returned for regAddressOut.
- txDataOut  output  N  stream word, registered.
- txValidOut  output  1  stream word valid, registered.
- txReadyIn  input  1  downstream accepts the word when high together with txValidOut.
- busyOut  output  1  high in every state except IDLE.
- doneOut  output  1  one-cycle pulse after the final word is accepted.

## Operation
- States: IDLE, LOAD, SEND, CSUM (macro only), DONE. 3-bit encoding.
- IDLE: index=0, outputs quiet. startIn=1 → LOAD.
- LOAD: regAddressOut=index. At the edge: txDataOut←regDataIn, txValidOut←1 → SEND.
- SEND: hold txDataOut/txValidOut stable until txValidOut&&txReadyIn at an edge.
  - On acceptance with index≠2^R_SIZE−1: index←index+1, txValidOut←0 → LOAD.
  - On acceptance with index=2^R_SIZE−1: txValidOut←0 → CSUM if enabled, otherwise DONE.
- DONE: doneOut=1 for exactly this cycle → IDLE.
- index is an R_SIZE-bit counter. The last-word check is explicit; the counter never wraps through 0 inside a dump.
- startIn outside IDLE is ignored. There is no queued restart.
- The dump is not atomic. A register written by the datapath before its LOAD cycle shows the new value; one written after shows the old value.
- Reset in any state: return to IDLE and clear all outputs and the index. An in-flight word is dropped and txValidOut falls on the next edge without handshake.

## Timing
- Reset values: regAddressOut=0, txDataOut=0, txValidOut=0, busyOut=0, doneOut=0.
- startIn high at edge t: busyOut=1 and LOAD in cycle t+1. First txValidOut=1 in cycle t+2.
- Per word: one LOAD cycle plus at least one SEND cycle. With txReadyIn held high, a word is emitted every 2 cycles.
- Full dump with txReadyIn=1 and no checksum: doneOut is high in cycle t+1+2·2^R_SIZE, which is cycle t+17 for R_SIZE=3. busyOut falls in the cycle after that.
- txReadyIn is a combinational input. No output depends combinationally on txReadyIn or regDataIn.
- regDataIn must settle within the LOAD cycle. The register file read is asynchronous, so there is no extra wait state.

## Configuration
- REG_DUMP_CHECKSUM_EN, when defined:
  - Adds the CSUM state and an N-bit accumulator.
  - The accumulator clears in IDLE and adds regDataIn (mod 2^N) in every LOAD cycle.
  - CSUM presents the accumulator as one extra stream word with the same SEND handshake. On acceptance → DONE.
  - Total stream length is 2^R_SIZE+1 words, and doneOut with ready held high moves 2 cycles later.
- Undefined: no CSUM state, no accumulator, and the stream is exactly 2^R_SIZE words.

## Structure
- Shared package reg_dump_pkg holds the state enum typedef (IDLE, LOAD, SEND, CSUM, DONE) and a localparam function for last index = (1<<R_SIZE)−1.
- Single module, no sub-modules. The FSM, index counter and checksum accumulator are small enough to live inline.
- The bench instantiates the existing register file, with regAddressOut on its sAddressIn and regDataIn from its sOut.

## Test plan
- Preload regs 0..7 with 0x10..0x17 and hold txReadyIn=1. Pulse startIn → stream 0x10..0x17 in order, one word every 2 cycles; doneOut pulses at t+17; busyOut low at t+18.
- Same preload with txReadyIn toggled 1-0-0-1 repeatedly → identical word sequence; txDataOut is stable while valid and not ready; no word is duplicated or lost.
- Assert reset during SEND of word 3 → next cycle all outputs are 0 and the FSM is in IDLE; a new startIn restarts from address 0.
- Pulse startIn again while busyOut=1 → ignored; exactly 8 words and one doneOut.
- Datapath writes reg 6=0xAA while the dump is at word 2 → word 6 is 0xAA; words 0..5 are unchanged.
- With REG_DUMP_CHECKSUM_EN and regs 0..7=0x10..0x17 → the 9th word is 0x9C (0x10+…+0x17 = 0x9C); doneOut pulses 2 cycles later than without the macro.
